seg_scan_reader: RTL and testbench

//  Receives a multiplexed 7-segment display bus (one-hot digit select plus segment lines)
//  and recovers the displayed BCD digits and decimal points. This is the inverse of the
//  BCD-to-segment encoder.

---
 rtl/seg_pkg.sv | 30 +++
 rtl/seg_scan_reader_if.sv | 28 ++
 rtl/seg_pattern_decode.sv | 37 +++
 rtl/seg_scan_reader.sv | 177 +++++++++++++++++
 tb/tb_seg_scan_reader.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_pkg
// Brief    : 7-segment pattern constants shared by the encoder and the reader.
// Revision : 1.0 - initial release
// ============================================================================
package seg_pkg;

    // Pattern bit order is {a,b,c,d,e,f,g}
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/seg_scan_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_reader_if
// Brief    : Scanned display bus in, recovered frame out.
// Revision : 1.0 - initial release
// ============================================================================
interface seg_scan_reader_if #(
    parameter int NDIG = 4
) ();
    logic [NDIG-1:0]   dig_sel;
    logic [7:0]        seg_in;
    logic [4*NDIG-1:0] frame_bcd;
    logic [NDIG-1:0]   frame_dp;
    logic [NDIG-1:0]   frame_err;
    logic              frame_valid;
    logic              lost;

    modport master (
        output dig_sel, seg_in,
        input  frame_bcd, frame_dp, frame_err, frame_valid, lost
    );

    modport slave (
        input  dig_sel, seg_in,
        output frame_bcd, frame_dp, frame_err, frame_valid, lost
    );
endinterface
`default_nettype wire

// File: rtl/seg_pattern_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg_pattern_decode
// Brief    : Combinational 7-bit segment pattern to BCD, blank and error flags.
// Revision : 1.0 - initial release
// ============================================================================
module seg_pattern_decode
    import seg_pkg::*;
(
    input  wire logic [6:0] i_pat,
    output logic      [3:0] o_bcd,
    output logic            o_blank,
    output logic            o_err
);

    always_comb begin
        o_bcd   = BCD_BLANK;
        o_blank = 1'b0;
        o_err   = 1'b0;
        case (i_pat)
            SEG_0:     o_bcd = 4'd0;
            SEG_1:     o_bcd = 4'd1;
            SEG_2:     o_bcd = 4'd2;
            SEG_3:     o_bcd = 4'd3;
            SEG_4:     o_bcd = 4'd4;
            SEG_5:     o_bcd = 4'd5;
            SEG_6:     o_bcd = 4'd6;
            SEG_7:     o_bcd = 4'd7;
            SEG_8:     o_bcd = 4'd8;
            SEG_9:     o_bcd = 4'd9;
            SEG_BLANK: o_blank = 1'b1;
            default:   o_err = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan_reader.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_reader
// Brief    : Recovers BCD digits and decimal points from a scanned 7-seg bus.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_reader
    import seg_pkg::*;
#(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 4,
    parameter int TIMEOUT    = 1024
) (
    input  wire logic         clk,
    input  wire logic         rst,
    seg_scan_reader_if.slave  bus
);

    localparam int STAB_W = $clog2(STABLE_CYC + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [STAB_W-1:0] C_STAB_ACC  = STAB_W'(STABLE_CYC - 1);
    localparam logic [STAB_W-1:0] C_STAB_MAX  = STAB_W'(STABLE_CYC);
    localparam logic [IDLE_W-1:0] C_IDLE_LAST = IDLE_W'(TIMEOUT - 1);
    localparam logic [IDLE_W-1:0] C_IDLE_MAX  = IDLE_W'(TIMEOUT);

    logic [NDIG-1:0]   s_sel_q, s_sel_d;
    logic [7:0]        s_seg_q, s_seg_d;
    logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic              lost_q, lost_d;
    scan_state_t       state_q, state_d;
    logic [NDIG-1:0]   got_q, got_d;
    logic [4*NDIG-1:0] stg_bcd_q, stg_bcd_d;
    logic [NDIG-1:0]   stg_dp_q, stg_dp_d;
    logic [NDIG-1:0]   stg_err_q, stg_err_d;
    logic [4*NDIG-1:0] frame_bcd_q, frame_bcd_d;
    logic [NDIG-1:0]   frame_dp_q, frame_dp_d;
    logic [NDIG-1:0]   frame_err_q, frame_err_d;
    logic              frame_valid_q, frame_valid_d;

    logic              w_same;
    logic              w_onehot;
    logic              w_accept;
    logic              w_timeout;
    logic [3:0]        w_dec_bcd;
    logic              w_dec_blank;
    logic              w_dec_err;

    seg_pattern_decode u_decode (
        .i_pat   (s_seg_q[7:1]),
        .o_bcd   (w_dec_bcd),
        .o_blank (w_dec_blank),
        .o_err   (w_dec_err)
    );

    // Datapath: input sampling, dwell counting, staging and timeout.
    always_comb begin
        s_sel_d  = bus.dig_sel;
        s_seg_d  = bus.seg_in;
        w_same   = (bus.dig_sel == s_sel_q) && (bus.seg_in == s_seg_q);
        w_onehot = (s_sel_q != '0) && ((s_sel_q & (s_sel_q - 1'b1)) == '0);

        // Saturating one past the accept value makes accept fire once per dwell.
        if (!w_same)
            stab_cnt_d = '0;
        else if (stab_cnt_q == C_STAB_MAX)
            stab_cnt_d = stab_cnt_q;
        else
            stab_cnt_d = stab_cnt_q + 1'b1;

        w_accept = (stab_cnt_q == C_STAB_ACC) && w_onehot;

        stg_bcd_d = stg_bcd_q;
        stg_dp_d  = stg_dp_q;
        stg_err_d = stg_err_q;
        for (int k = 0; k < NDIG; k++) begin
            if (w_accept && s_sel_q[k]) begin
                stg_bcd_d[4*k +: 4] = w_dec_bcd;
                stg_dp_d[k]         = s_seg_q[0];
                stg_err_d[k]        = w_dec_err && !w_dec_blank;
            end
        end

        if (w_accept)
            idle_cnt_d = '0;
        else if (idle_cnt_q == C_IDLE_MAX)
            idle_cnt_d = idle_cnt_q;
        else
            idle_cnt_d = idle_cnt_q + 1'b1;

        w_timeout = !w_accept && (idle_cnt_q == C_IDLE_LAST);
        lost_d    = w_accept ? 1'b0 : (w_timeout ? 1'b1 : lost_q);
    end

    always_comb begin
        state_d       = state_q;
        got_d         = got_q;
        frame_bcd_d   = frame_bcd_q;
        frame_dp_d    = frame_dp_q;
        frame_err_d   = frame_err_q;
        frame_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    got_d   = s_sel_q;
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (w_accept) begin
                    got_d = got_q | s_sel_q;
                end else if (w_timeout) begin
                    got_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                frame_bcd_d   = stg_bcd_q;
                frame_dp_d    = stg_dp_q;
                frame_err_d   = stg_err_q;
                frame_valid_d = 1'b1;
                got_d         = w_accept ? s_sel_q : '0;
                state_d       = w_accept ? ST_COLLECT : ST_IDLE;
            end
            default: begin
                got_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        if (w_accept && (&got_d))
            state_d = ST_DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_sel_q       <= '0;
            s_seg_q       <= '0;
            stab_cnt_q    <= '0;
            idle_cnt_q    <= '0;
            lost_q        <= 1'b0;
            state_q       <= ST_IDLE;
            got_q         <= '0;
            stg_bcd_q     <= '0;
            stg_dp_q      <= '0;
            stg_err_q     <= '0;
            frame_bcd_q   <= '0;
            frame_dp_q    <= '0;
            frame_err_q   <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            s_sel_q       <= s_sel_d;
            s_seg_q       <= s_seg_d;
            stab_cnt_q    <= stab_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            lost_q        <= lost_d;
            state_q       <= state_d;
            got_q         <= got_d;
            stg_bcd_q     <= stg_bcd_d;
            stg_dp_q      <= stg_dp_d;
            stg_err_q     <= stg_err_d;
            frame_bcd_q   <= frame_bcd_d;
            frame_dp_q    <= frame_dp_d;
            frame_err_q   <= frame_err_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    assign bus.frame_bcd   = frame_bcd_q;
    assign bus.frame_dp    = frame_dp_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.lost        = lost_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_reader
// Brief    : Directed self-checking bench for seg_scan_reader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_reader;

    localparam int NDIG       = 4;
    localparam int STABLE_CYC = 4;
    localparam int TIMEOUT    = 200;

    logic clk;
    logic rst;
    int   cyc        = 0;
    int   fv_cnt     = 0;
    int   fv_cyc     = 0;
    int   last_start = 0;
    int   n_checks   = 0;
    int   n_errors   = 0;
    int   base;
    logic [6:0] seg_tab [10];

    seg_scan_reader_if #(.NDIG(NDIG)) bus ();

    seg_scan_reader #(
        .NDIG       (NDIG),
        .STABLE_CYC (STABLE_CYC),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.frame_valid === 1'b1) begin
            fv_cnt = fv_cnt + 1;
            fv_cyc = cyc;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] dpat(input int d, input logic dp);
        return {seg_tab[d], dp};
    endfunction

    // One dwell on digit k, followed by a two-cycle zero-select gap.
    task automatic show(input int k, input logic [7:0] seg, input int hold);
        logic [NDIG-1:0] sel;
        sel         = '0;
        sel[k]      = 1'b1;
        bus.dig_sel = sel;
        bus.seg_in  = seg;
        last_start  = cyc;
        tick(hold);
        bus.dig_sel = '0;
        bus.seg_in  = '0;
        tick(2);
    endtask

    initial begin
        seg_tab[0] = 7'b1111110; seg_tab[1] = 7'b0110000;
        seg_tab[2] = 7'b1101101; seg_tab[3] = 7'b1111001;
        seg_tab[4] = 7'b0110011; seg_tab[5] = 7'b1011011;
        seg_tab[6] = 7'b1011111; seg_tab[7] = 7'b1110000;
        seg_tab[8] = 7'b1111111; seg_tab[9] = 7'b1111011;

        rst         = 1'b1;
        bus.dig_sel = '0;
        bus.seg_in  = '0;
        tick(3);
        check_val("rst_bcd",   32'(bus.frame_bcd),   32'h0);
        check_val("rst_dp",    32'(bus.frame_dp),    32'h0);
        check_val("rst_err",   32'(bus.frame_err),   32'h0);
        check_val("rst_valid", 32'(bus.frame_valid), 32'h0);
        check_val("rst_lost",  32'(bus.lost),        32'h0);
        rst = 1'b0;
        tick(2);

        // Plain scan 1,2,3,4
        base = fv_cnt;
        for (int d = 1; d <= 4; d++) show(d - 1, dpat(d, 1'b0), 6);
        tick(2);
        check_val("t1_fv_count", 32'(fv_cnt - base), 32'd1);
        check_val("t1_latency",  32'(fv_cyc - last_start), 32'(STABLE_CYC + 2));
        check_val("t1_bcd",      32'(bus.frame_bcd), 32'h4321);
        check_val("t1_err",      32'(bus.frame_err), 32'h0);
        check_val("t1_dp",       32'(bus.frame_dp),  32'h0);

        // Bad pattern, blank, 8 with dp, 9
        base = fv_cnt;
        show(0, 8'b1000001_0, 6);
        show(1, 8'h00, 6);
        show(2, dpat(8, 1'b1), 6);
        show(3, dpat(9, 1'b0), 6);
        tick(2);
        check_val("t2_fv_count", 32'(fv_cnt - base), 32'd1);
        check_val("t2_bcd",      32'(bus.frame_bcd), 32'h98FF);
        check_val("t2_dp",       32'(bus.frame_dp),  32'b0100);
        check_val("t2_err",      32'(bus.frame_err), 32'b0001);

        // Dwell too short: nothing accepted, link eventually lost
        check_val("t3_lost_early", 32'(bus.lost), 32'h0);
        base = fv_cnt;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < NDIG; k++) begin
                bus.dig_sel    = '0;
                bus.dig_sel[k] = 1'b1;
                bus.seg_in     = dpat(k + 1, 1'b0);
                tick(3);
            end
        end
        bus.dig_sel = '0;
        bus.seg_in  = '0;
        for (int i = 0; i < 2 * TIMEOUT && bus.lost !== 1'b1; i++) tick(1);
        check_val("t3_fv_count", 32'(fv_cnt - base), 32'd0);
        check_val("t3_lost",     32'(bus.lost), 32'h1);
        check_val("t3_retained", 32'(bus.frame_bcd), 32'h98FF);

        // Multi-hot select is never accepted
        base        = fv_cnt;
        bus.dig_sel = 4'b0011;
        bus.seg_in  = dpat(5, 1'b0);
        tick(10);
        bus.dig_sel = '0;
        bus.seg_in  = '0;
        tick(2);
        check_val("t4_multi_fv",   32'(fv_cnt - base), 32'd0);
        check_val("t4_multi_lost", 32'(bus.lost), 32'h1);
        show(0, dpat(5, 1'b0), 6);
        show(1, dpat(6, 1'b0), 6);
        show(2, dpat(7, 1'b0), 6);
        show(3, dpat(0, 1'b0), 6);
        tick(2);
        check_val("t4_fv_count", 32'(fv_cnt - base), 32'd1);
        check_val("t4_bcd",      32'(bus.frame_bcd), 32'h0765);
        check_val("t4_lost",     32'(bus.lost), 32'h0);

        // Repeat of digit 1: latest value wins
        base = fv_cnt;
        show(0, dpat(1, 1'b0), 6);
        show(1, dpat(5, 1'b0), 6);
        show(2, dpat(2, 1'b0), 6);
        show(1, dpat(7, 1'b0), 6);
        check_val("t5_fv_early", 32'(fv_cnt - base), 32'd0);
        show(3, dpat(3, 1'b0), 6);
        tick(2);
        check_val("t5_fv_count", 32'(fv_cnt - base), 32'd1);
        check_val("t5_bcd",      32'(bus.frame_bcd), 32'h3271);

        // Reset mid-frame
        base = fv_cnt;
        show(0, dpat(8, 1'b0), 6);
        show(1, dpat(8, 1'b1), 6);
        rst = 1'b1;
        tick(1);
        check_val("t6_rst_bcd",   32'(bus.frame_bcd),   32'h0);
        check_val("t6_rst_valid", 32'(bus.frame_valid), 32'h0);
        check_val("t6_rst_err",   32'(bus.frame_err),   32'h0);
        tick(2);
        rst = 1'b0;
        tick(2);
        check_val("t6_fv_none", 32'(fv_cnt - base), 32'd0);
        for (int d = 2; d <= 5; d++) show(d - 2, dpat(d, 1'b0), 6);
        tick(2);
        check_val("t6_fv_count", 32'(fv_cnt - base), 32'd1);
        check_val("t6_bcd",      32'(bus.frame_bcd), 32'h5432);
        check_val("t6_dp",       32'(bus.frame_dp),  32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
